// File: rtl/tm1638_spi_responder.sv
// TM1638 device-side serial front-end: decodes STB/CLK/DIO frames into display RAM writes,
// display control and key-read responses. Optional shadow RAM: TM1638_SPI_RESPONDER_SHADOW_RAM_EN.
module tm1638_spi_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_BITS   = 4
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst_n,
   input  logic                 i_SPI_Stb,
   input  logic                 i_SPI_Clk,
   input  logic                 i_SPI_Dio,
   input  logic [31:0]          i_Keys,
   output logic                 o_SPI_Dio,
   output logic                 o_SPI_Dio_Oe,
   output logic                 o_Ram_Wr,
   output logic [ADDR_BITS-1:0] o_Ram_Addr,
   output logic [7:0]           o_Ram_Data,
   output logic                 o_Display_On,
   output logic [2:0]           o_Brightness,
   output logic [2:0]           o_Diag_State,
`ifdef TM1638_SPI_RESPONDER_SHADOW_RAM_EN
   input  logic [ADDR_BITS-1:0] i_Rd_Addr,
   output logic [7:0]           o_Rd_Data,
`endif
   output logic                 o_Diag_Frame_Error
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      DATA_WR = 3'd2,
      KEY_RD  = 3'd3,
      IGNORE  = 3'd4
   } state_t;

   state_t r_state, w_state_next;

   logic [SYNC_STAGES-1:0] r_stb_sync, r_clk_sync, r_dio_sync;
   logic                   r_stb_prev, r_clk_prev, r_armed;
   logic                   w_stb, w_clk, w_dio;
   logic                   w_stb_fall, w_stb_rise, w_active, w_sck_rise, w_sck_fall;

   logic [7:0]             r_shift;
   logic [2:0]             r_bit_cnt;
   logic                   r_byte_done;

   logic                   r_mode_read, r_mode_fixed;
   logic [ADDR_BITS-1:0]   r_ptr;
   logic                   r_ram_wr;
   logic [ADDR_BITS-1:0]   r_ram_addr;
   logic [7:0]             r_ram_data;
   logic                   r_disp_on;
   logic [2:0]             r_bright;
   logic                   r_frame_err;
   logic                   r_oe, r_dio;
   logic [31:0]            r_keys;
   logic [5:0]             r_key_idx;

   // STB chain resets low so a frame already in progress at reset release is not seen as a new one.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_stb_sync <= '0;
         r_clk_sync <= '1;
         r_dio_sync <= '1;
         r_stb_prev <= 1'b1;
         r_clk_prev <= 1'b1;
         r_armed    <= 1'b0;
      end else begin
         r_stb_sync <= {r_stb_sync[SYNC_STAGES-2:0], i_SPI_Stb};
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_SPI_Clk};
         r_dio_sync <= {r_dio_sync[SYNC_STAGES-2:0], i_SPI_Dio};
         r_stb_prev <= w_stb;
         r_clk_prev <= w_clk;
         if (w_stb) r_armed <= 1'b1;
      end
   end

   assign w_stb      = r_stb_sync[SYNC_STAGES-1];
   assign w_clk      = r_clk_sync[SYNC_STAGES-1];
   assign w_dio      = r_dio_sync[SYNC_STAGES-1];
   assign w_stb_fall = r_armed & r_stb_prev & ~w_stb;
   assign w_stb_rise = r_armed & ~r_stb_prev & w_stb;
   assign w_active   = r_armed & ~w_stb;
   assign w_sck_rise = w_active & w_clk & ~r_clk_prev;
   assign w_sck_fall = w_active & ~w_clk & r_clk_prev;

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_byte_done <= 1'b0;
      end else begin
         r_byte_done <= 1'b0;
         if (w_stb_fall || w_stb_rise) begin
            r_bit_cnt <= '0;
         end else if (w_sck_rise) begin
            r_shift[r_bit_cnt] <= w_dio;
            r_bit_cnt          <= r_bit_cnt + 3'd1;
            r_byte_done        <= (r_bit_cnt == 3'd7);
         end
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (w_stb_rise) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE: if (w_stb_fall) w_state_next = CMD;
            CMD: begin
               if (r_byte_done) begin
                  case (r_shift[7:6])
                     2'b01:   w_state_next = r_shift[1] ? KEY_RD : IGNORE;
                     2'b11:   w_state_next = r_mode_read ? IGNORE : DATA_WR;
                     default: w_state_next = IGNORE;
                  endcase
               end
            end
            default: w_state_next = r_state;
         endcase
      end
   end

   // A byte completing in the same cycle as STB rise is still executed; only a partial byte is flagged.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_mode_read  <= 1'b0;
         r_mode_fixed <= 1'b0;
         r_ptr        <= '0;
         r_ram_wr     <= 1'b0;
         r_ram_addr   <= '0;
         r_ram_data   <= '0;
         r_disp_on    <= 1'b0;
         r_bright     <= '0;
         r_frame_err  <= 1'b0;
         r_oe         <= 1'b0;
         r_dio        <= 1'b1;
         r_keys       <= '0;
         r_key_idx    <= '0;
      end else begin
         r_ram_wr    <= 1'b0;
         r_frame_err <= 1'b0;
         if (r_byte_done) begin
            case (r_state)
               CMD: begin
                  case (r_shift[7:6])
                     2'b01: begin
                        r_mode_read  <= r_shift[1];
                        r_mode_fixed <= r_shift[2];
                        if (r_shift[1]) begin
                           r_keys    <= i_Keys;
                           r_key_idx <= '0;
                           r_oe      <= 1'b1;
                        end
                     end
                     2'b10: begin
                        r_disp_on <= r_shift[3];
                        r_bright  <= r_shift[2:0];
                     end
                     2'b11:   r_ptr <= r_shift[ADDR_BITS-1:0];
                     default: ;
                  endcase
               end
               DATA_WR: begin
                  r_ram_wr   <= 1'b1;
                  r_ram_addr <= r_ptr;
                  r_ram_data <= r_shift;
                  if (!r_mode_fixed) r_ptr <= r_ptr + ADDR_BITS'(1);
               end
               default: ;
            endcase
         end
         if (r_state == KEY_RD) begin
            if (w_sck_fall) begin
               if (!r_key_idx[5]) begin
                  r_dio     <= r_keys[r_key_idx[4:0]];
                  r_key_idx <= r_key_idx + 6'd1;
               end else begin
                  r_dio <= 1'b1;
               end
            end else if (w_sck_rise && r_key_idx[5]) begin
               r_dio <= 1'b1;
            end
         end
         if (w_stb_rise) begin
            r_oe        <= 1'b0;
            r_dio       <= 1'b1;
            r_frame_err <= (r_bit_cnt != 3'd0);
         end
      end
   end

`ifdef TM1638_SPI_RESPONDER_SHADOW_RAM_EN
   logic [7:0] w_cells [2**ADDR_BITS];
   logic [7:0] r_rd_data;

   generate
      for (genvar gi = 0; gi < 2**ADDR_BITS; gi++) begin : g_shadow
         logic [7:0] r_cell;
         always_ff @(posedge i_Clk or negedge i_Rst_n) begin
            if (!i_Rst_n)                                          r_cell <= '0;
            else if (r_ram_wr && (r_ram_addr == ADDR_BITS'(gi))) r_cell <= r_ram_data;
         end
         assign w_cells[gi] = r_cell;
      end
   endgenerate

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) r_rd_data <= '0;
      else          r_rd_data <= w_cells[i_Rd_Addr];
   end
   assign o_Rd_Data = r_rd_data;
`endif

   assign o_SPI_Dio          = r_dio;
   assign o_SPI_Dio_Oe       = r_oe;
   assign o_Ram_Wr           = r_ram_wr;
   assign o_Ram_Addr         = r_ram_addr;
   assign o_Ram_Data         = r_ram_data;
   assign o_Display_On       = r_disp_on;
   assign o_Brightness       = r_bright;
   assign o_Diag_State       = r_state;
   assign o_Diag_Frame_Error = r_frame_err;

endmodule

// File: tb/tb_tm1638_spi_responder.sv
// Self-checking bench for tm1638_spi_responder: directed frame table, key reads,
// partial-byte and mid-frame reset sequences, then random frames against a command-level model.
module tb_tm1638_spi_responder;

   localparam int H = 5;   // SPI half period in system clocks

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        stb = 1'b1;
   logic        sclk = 1'b1;
   logic        dio = 1'b1;
   logic [31:0] keys_in = '0;
   logic        o_dio, o_oe, o_wr, o_disp, o_ferr;
   logic [3:0]  o_addr;
   logic [7:0]  o_data;
   logic [2:0]  o_bri, o_state;
`ifdef TM1638_SPI_RESPONDER_SHADOW_RAM_EN
   logic [3:0]  rd_addr = '0;
   logic [7:0]  rd_data;
`endif

   always #5 clk = ~clk;

   tm1638_spi_responder #(.SYNC_STAGES(2), .ADDR_BITS(4)) dut (
      .i_Clk(clk), .i_Rst_n(rst_n),
      .i_SPI_Stb(stb), .i_SPI_Clk(sclk), .i_SPI_Dio(dio), .i_Keys(keys_in),
      .o_SPI_Dio(o_dio), .o_SPI_Dio_Oe(o_oe),
      .o_Ram_Wr(o_wr), .o_Ram_Addr(o_addr), .o_Ram_Data(o_data),
      .o_Display_On(o_disp), .o_Brightness(o_bri), .o_Diag_State(o_state),
`ifdef TM1638_SPI_RESPONDER_SHADOW_RAM_EN
      .i_Rd_Addr(rd_addr), .o_Rd_Data(rd_data),
`endif
      .o_Diag_Frame_Error(o_ferr)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [11:0] wr_q[$];
   logic [11:0] exp_q[$];
   int ferr_cnt = 0;

   // command-level model state
   logic       m_read, m_fixed, m_disp;
   logic [3:0] m_ptr;
   logic [2:0] m_bri;

   typedef struct {
      int          nb;
      logic [31:0] bytes;
      int          nwr;
      logic [35:0] wrs;
      logic        disp;
      logic [2:0]  bri;
   } vec_t;
   vec_t tbl [11];

   always @(negedge clk) begin
      if (o_wr) wr_q.push_back({o_addr, o_data});
      if (o_ferr) ferr_cnt++;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] b, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b0; dio = b[i]; cyc(H);
         sclk = 1'b1; cyc(H);
      end
   endtask

   task automatic send_frame(input int nb, input logic [31:0] bytes);
      stb = 1'b0; cyc(H);
      for (int i = 0; i < nb; i++) send_bits(bytes[8*i +: 8], 8);
      dio = 1'b1; cyc(H);
      stb = 1'b1; cyc(12);
   endtask

   task automatic model_frame(input int nb, input logic [31:0] bytes);
      logic [7:0] c;
      c = bytes[7:0];
      if (c[7:6] == 2'b01) begin
         m_read = c[1]; m_fixed = c[2];
      end else if (c[7:6] == 2'b10) begin
         m_disp = c[3]; m_bri = c[2:0];
      end else if (c[7:6] == 2'b11) begin
         m_ptr = c[3:0];
         if (!m_read) begin
            for (int i = 1; i < nb; i++) begin
               exp_q.push_back({m_ptr, bytes[8*i +: 8]});
               if (!m_fixed) m_ptr = m_ptr + 4'd1;
            end
         end
      end
   endtask

   task automatic compare_writes(input string tag);
      chk({tag, " write count"}, 64'(wr_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
         chk($sformatf("%s write %0d", tag, i), 64'(wr_q[i]), 64'(exp_q[i]));
      wr_q.delete();
      exp_q.delete();
   endtask

   task automatic key_read(input logic [31:0] keys);
      logic [31:0] got;
      int oe_bad;
      got = '0; oe_bad = 0;
      keys_in = keys;
      stb = 1'b0; cyc(H);
      send_bits(8'h42, 8);
      cyc(H);
      keys_in = ~keys;
      chk("keyrd oe after cmd", 64'(o_oe), 64'd1);
      for (int i = 0; i < 32; i++) begin
         sclk = 1'b0; dio = 1'b1; cyc(H);
         got[i] = o_dio;
         if (o_oe !== 1'b1) oe_bad++;
         sclk = 1'b1; cyc(H);
      end
      chk("keyrd data", 64'(got), 64'(keys));
      chk("keyrd oe during bits", 64'(oe_bad), 64'd0);
      chk("keyrd dio after 32 bits", 64'(o_dio), 64'd1);
      chk("keyrd oe held after 32 bits", 64'(o_oe), 64'd1);
      stb = 1'b1; cyc(12);
      chk("keyrd oe after stb", 64'(o_oe), 64'd0);
      chk("keyrd dio after stb", 64'(o_dio), 64'd1);
      m_read = 1'b1; m_fixed = 1'b0;
      $display("key read keys=%h sampled=%h", keys, got);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, " dio"},   64'(o_dio),   64'd1);
      chk({tag, " oe"},    64'(o_oe),    64'd0);
      chk({tag, " wr"},    64'(o_wr),    64'd0);
      chk({tag, " addr"},  64'(o_addr),  64'd0);
      chk({tag, " data"},  64'(o_data),  64'd0);
      chk({tag, " disp"},  64'(o_disp),  64'd0);
      chk({tag, " bri"},   64'(o_bri),   64'd0);
      chk({tag, " state"}, 64'(o_state), 64'd0);
      chk({tag, " ferr"},  64'(o_ferr),  64'd0);
   endtask

   initial begin
      tbl[0]  = '{1, 32'h0000_0040, 0, 36'h000_000_000, 1'b0, 3'd0};
      tbl[1]  = '{4, 32'h5B06_3FC0, 3, 36'h25B_106_03F, 1'b0, 3'd0};
      tbl[2]  = '{1, 32'h0000_0040, 0, 36'h000_000_000, 1'b0, 3'd0};
      tbl[3]  = '{3, 32'h00BB_AACF, 2, 36'h000_0BB_FAA, 1'b0, 3'd0};
      tbl[4]  = '{1, 32'h0000_0044, 0, 36'h000_000_000, 1'b0, 3'd0};
      tbl[5]  = '{3, 32'h0022_11C5, 2, 36'h000_522_511, 1'b0, 3'd0};
      tbl[6]  = '{1, 32'h0000_008B, 0, 36'h000_000_000, 1'b1, 3'd3};
      tbl[7]  = '{1, 32'h0000_0080, 0, 36'h000_000_000, 1'b0, 3'd0};
      tbl[8]  = '{1, 32'h0000_0040, 0, 36'h000_000_000, 1'b0, 3'd0};
      tbl[9]  = '{2, 32'h0000_5500, 0, 36'h000_000_000, 1'b0, 3'd0};
      tbl[10] = '{2, 32'h0000_AAC7, 1, 36'h000_000_7AA, 1'b0, 3'd0};

      #1 rst_n = 1'b0;
      #2 check_reset_values("reset");
      cyc(3);
      rst_n = 1'b1;
      cyc(6);

      for (int v = 0; v < 11; v++) begin
         wr_q.delete(); ferr_cnt = 0;
         send_frame(tbl[v].nb, tbl[v].bytes);
         chk($sformatf("vec%0d write count", v), 64'(wr_q.size()), 64'(tbl[v].nwr));
         for (int i = 0; i < tbl[v].nwr && i < wr_q.size(); i++)
            chk($sformatf("vec%0d write %0d", v, i), 64'(wr_q[i]), 64'(tbl[v].wrs[12*i +: 12]));
         chk($sformatf("vec%0d disp", v), 64'(o_disp), 64'(tbl[v].disp));
         chk($sformatf("vec%0d bri", v), 64'(o_bri), 64'(tbl[v].bri));
         chk($sformatf("vec%0d frame err", v), 64'(ferr_cnt), 64'd0);
         $display("vector %0d bytes=%h writes=%0d disp=%b bri=%0d", v, tbl[v].bytes, wr_q.size(), o_disp, o_bri);
      end

      m_disp = 1'b0; m_bri = 3'd0; m_ptr = 4'd8; m_fixed = 1'b0; m_read = 1'b0;
      key_read(32'h8001_4002);
      for (int k = 0; k < 2; k++) key_read($urandom);

      // partial byte discarded with a single error pulse
      send_frame(1, 32'h40);
      wr_q.delete(); ferr_cnt = 0;
      stb = 1'b0; cyc(H);
      send_bits(8'hC0, 8);
      send_bits(8'h1F, 5);
      cyc(H); stb = 1'b1; cyc(12);
      chk("partial frame err pulses", 64'(ferr_cnt), 64'd1);
      chk("partial no write", 64'(wr_q.size()), 64'd0);
      $display("partial byte frame: err pulses=%0d writes=%0d", ferr_cnt, wr_q.size());

      // reset in the middle of a data-write frame
      send_frame(1, 32'h8F);
      chk("disp before reset", 64'(o_disp), 64'd1);
      chk("bri before reset", 64'(o_bri), 64'd7);
      send_frame(1, 32'h40);
      stb = 1'b0; cyc(H);
      send_bits(8'hC0, 8);
      send_bits(8'h12, 8);
      send_bits(8'h55, 3);
      rst_n = 1'b0;
      #2 check_reset_values("midframe reset");
      cyc(3);
      rst_n = 1'b1;
      wr_q.delete(); ferr_cnt = 0;
      send_bits(8'h0A, 5);
      send_bits(8'h99, 8);
      cyc(H); stb = 1'b1; cyc(12);
      chk("after reset remainder writes", 64'(wr_q.size()), 64'd0);
      chk("after reset remainder ferr", 64'(ferr_cnt), 64'd0);
      send_frame(1, 32'h40);
      send_frame(2, 32'h77C3);
      chk("after reset write count", 64'(wr_q.size()), 64'd1);
      if (wr_q.size() > 0) chk("after reset write", 64'(wr_q[0]), 64'h377);
      $display("reset recovery: writes=%0d", wr_q.size());
`ifdef TM1638_SPI_RESPONDER_SHADOW_RAM_EN
      rd_addr = 4'd3; cyc(2);
      chk("shadow read addr3", 64'(rd_data), 64'h77);
`endif
      wr_q.delete();

      m_read = 1'b0; m_fixed = 1'b0; m_ptr = 4'd4; m_disp = 1'b0; m_bri = 3'd0;
      for (int r = 0; r < 40; r++) begin
         logic [31:0] bytes;
         int nb, kind;
         bytes = $urandom;
         kind  = $urandom_range(0, 3);
         nb    = 1;
         case (kind)
            0: begin bytes[7:6] = 2'b01; bytes[1] = ($urandom_range(0, 3) == 0); end
            1: begin bytes[7:6] = 2'b11; nb = $urandom_range(1, 4); end
            2: bytes[7:6] = 2'b10;
            default: begin bytes[7:6] = 2'b00; nb = $urandom_range(1, 4); end
         endcase
         ferr_cnt = 0;
         model_frame(nb, bytes);
         send_frame(nb, bytes);
         $display("random %0d nb=%0d bytes=%h writes=%0d", r, nb, bytes, wr_q.size());
         compare_writes($sformatf("rand%0d", r));
         chk($sformatf("rand%0d disp", r), 64'(o_disp), 64'(m_disp));
         chk($sformatf("rand%0d bri", r), 64'(o_bri), 64'(m_bri));
         chk($sformatf("rand%0d oe", r), 64'(o_oe), 64'd0);
         chk($sformatf("rand%0d frame err", r), 64'(ferr_cnt), 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
